// File: rtl/tdm_mux.sv
// Round-robin time-division multiplexer: N_CH single-entry channel buffers
// drained one slot per enabled clock onto a registered output stream.
module tdm_mux #(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned W     = 1,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  output logic [W-1:0]      Y,
  output logic [SEL_W-1:0]  Sel,
  output logic              out_valid,
  output logic              frame_sync
);

  logic [SEL_W-1:0]          slot_q, slot_d;
  logic [N_CH-1:0]           full_q, full_d;
  logic [N_CH-1:0][W-1:0]    hold_q, hold_d;
  logic [W-1:0]              y_q, y_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic                      out_valid_q, out_valid_d;
  logic                      frame_sync_q, frame_sync_d;

  // A full channel only reopens in the cycle its own slot is being drained.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      in_ready[i] = ~full_q[i] | (en & (slot_q == SEL_W'(i)));
    end
  end

  always_comb begin
    slot_d       = slot_q;
    full_d       = full_q;
    hold_d       = hold_q;
    y_d          = y_q;
    sel_d        = sel_q;
    out_valid_d  = out_valid_q;
    frame_sync_d = frame_sync_q;

    if (en) begin
      y_d               = full_q[slot_q] ? hold_q[slot_q] : '0;
      out_valid_d       = full_q[slot_q];
      sel_d             = slot_q;
      frame_sync_d      = (slot_q == '0);
      full_d[slot_q]    = 1'b0;
      slot_d            = slot_q + SEL_W'(1);
    end

    // Loads come after the drain so a same-slot refill keeps the channel full.
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        hold_d[i] = in_data[i*W +: W];
        full_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      full_q       <= '0;
      hold_q       <= '0;
      y_q          <= '0;
      sel_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_sync_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      full_q       <= full_d;
      hold_q       <= hold_d;
      y_q          <= y_d;
      sel_q        <= sel_d;
      out_valid_q  <= out_valid_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign Y          = y_q;
  assign Sel        = sel_q;
  assign out_valid  = out_valid_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: doc/tdm_mux.md
# tdm_mux

Time-division multiplexer that merges `N_CH` independent input channels onto one output stream, one slot per clock, in a fixed round-robin frame. Each channel has a one-entry holding register with a valid/ready handshake. The output carries data, slot index, a per-slot valid flag and a frame-start marker, so a downstream 1-to-N demultiplexer can route every word back to its channel.

## Interface
- `N_CH`, 4: number of input channels / slots per frame; must be ≥2 and a power of two.
- `W`, 1: data width per channel.
- `SEL_W`, log2(`N_CH`) (2): width of slot index; derived, not overridden.
- `clk`  input  1  rising-edge clock; the block has one clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  frame advance enable; when 0 the slot counter and outputs hold.
- `in_data`  input  `N_CH`*`W`  channel i occupies bits [i*W +: W].
- `in_valid`  input  `N_CH`  channel i offers a word.
- `in_ready`  output  `N_CH`  channel i accepts a word this cycle (combinational).
- `Y`  output  `W`  registered output word.
- `Sel`  output  `SEL_W`  registered slot index of `Y`.
- `out_valid`  output  1  registered; `Y` holds a real word for slot `Sel`.
- `frame_sync`  output  1  registered; high while `Sel` = 0 and `en` advanced.

## Operation
- State:
  - slot counter `slot` (`SEL_W` bits);
  - per-channel `full[i]` flag and `hold[i]` (`W` bits).
- Load:
  - When `in_valid[i] & in_ready[i]` at a rising edge: `hold[i]` ← word, `full[i]` ← 1.
  - `in_ready[i] = ~full[i] | (en & slot == i)`. A full channel can be refilled in the cycle its slot drains it.
- Transmit, on each edge with `en` = 1:
  - `Y` ← `hold[slot]` if `full[slot]`, else 0.
  - `out_valid` ← `full[slot]`.
  - `Sel` ← `slot`.
  - `frame_sync` ← (`slot` == 0).
  - `full[slot]` ← 0, unless a simultaneous load of that channel occurs. Load wins: `full` stays 1 and `hold` takes the new word. The old word is the one transmitted.
  - `slot` ← `slot` + 1, wrapping from `N_CH`−1 to 0 (natural modulo 2^`SEL_W`).
- `en` = 0:
  - `slot`, `Y`, `Sel`, `out_valid` and `frame_sync` hold their values.
  - Loads into non-full channels still proceed; full channels show `in_ready` = 0.
- Empty slots are never skipped; frame length is always `N_CH` enabled cycles.
- Each accepted word is transmitted exactly once; no word is dropped or duplicated.

## Timing
- Reset (asynchronous on `rst_n` falling, released synchronously to `clk` by the system):
  - `slot` = 0, all `full` = 0, all `hold` = 0.
  - `Y` = 0, `Sel` = 0, `out_valid` = 0, `frame_sync` = 0.
  - `in_ready` = all 1s during and after reset.
- Reset mid-frame: all held words are discarded, and the next enabled edge transmits slot 0 with `frame_sync` = 1.
- Latency: a word loaded at edge k into channel i appears on `Y` at the first enabled edge after k at which `slot` == i. Minimum 1 cycle, maximum `N_CH` enabled cycles.
- Outputs change only on `clk` rising edges or reset; `in_ready` is the only combinational output.
- With `en` held high, `frame_sync` pulses exactly once every `N_CH` cycles, one cycle wide.

## Test plan
- Reset: `rst_n` = 0 mid-frame with all channels full. Required: `Y` = 0, `Sel` = 0, `out_valid` = 0, `frame_sync` = 0 and `in_ready` = 4'b1111 immediately, before any clock. After release with `en` = 1, the first output is `Sel` = 0, `frame_sync` = 1, `out_valid` = 0.
- Single word: `W` = 1, load channel 2 with 1 while `slot` = 0. Required: `Y` = 1, `Sel` = 2, `out_valid` = 1 exactly one edge after `slot` reaches 2. Slots 0, 1 and 3 show `out_valid` = 0, `Y` = 0.
- Full frame, `W` = 8: preload channels 0..3 with 8'hA0, 8'hB1, 8'hC2, 8'hD3, then assert `en`. Required: the sequence (0, A0, sync = 1), (1, B1), (2, C2), (3, D3). The next frame shows all `out_valid` = 0.
- Back-pressure: hold `in_valid[1]` = 1 while `full[1]` = 1. Required: `in_ready[1]` = 0 except in the cycle `slot` == 1 with `en` = 1. In that cycle the old word is sent and the new word is captured with no gap.
- Enable stall: drop `en` for 3 cycles at `slot` = 2. Required: `Y`, `Sel`, `out_valid` and `frame_sync` frozen. The frame resumes with slot 2 and `frame_sync` recurs every 4 enabled cycles.
- Wrap / stress: random `in_valid` for 1000 cycles with `en` = 1. Scoreboard checks:
  - every accepted word is emitted once, in order per channel;
  - `Sel` increments modulo 4;
  - `frame_sync` is asserted only when `Sel` = 0.
